// File: rtl/spi_acl2_axil_slave.sv
// rtl/spi_acl2_axil_slave.sv - AXI4-Lite register front-end for the SPI_ACL2 core (four regs, write strobes)
// Optional SPI_ACL2_HW_STATUS_EN: register 3 becomes read-only and mirrors status_in.
module spi_acl2_axil_slave #(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 4
) (
  input  logic                              s00_axi_aclk,
  input  logic                              s00_axi_aresetn,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]     s00_axi_awaddr,
  input  logic [2:0]                        s00_axi_awprot,
  input  logic                              s00_axi_awvalid,
  output logic                              s00_axi_awready,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]     s00_axi_wdata,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0]   s00_axi_wstrb,
  input  logic                              s00_axi_wvalid,
  output logic                              s00_axi_wready,
  output logic [1:0]                        s00_axi_bresp,
  output logic                              s00_axi_bvalid,
  input  logic                              s00_axi_bready,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]     s00_axi_araddr,
  input  logic [2:0]                        s00_axi_arprot,
  input  logic                              s00_axi_arvalid,
  output logic                              s00_axi_arready,
  output logic [C_S_AXI_DATA_WIDTH-1:0]     s00_axi_rdata,
  output logic [1:0]                        s00_axi_rresp,
  output logic                              s00_axi_rvalid,
  input  logic                              s00_axi_rready,
  output logic [C_S_AXI_DATA_WIDTH-1:0]     reg0_out,
  output logic [C_S_AXI_DATA_WIDTH-1:0]     reg1_out,
  output logic [C_S_AXI_DATA_WIDTH-1:0]     reg2_out,
  output logic [C_S_AXI_DATA_WIDTH-1:0]     reg3_out,
  output logic [3:0]                        wr_pulse,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]     status_in
);

  typedef enum logic [1:0] {W_IDLE, W_HALF, W_RESP} wstate_t;
  typedef enum logic {R_IDLE, R_RESP} rstate_t;

  wstate_t                         r_wstate;
  rstate_t                         r_rstate;
  logic [C_S_AXI_DATA_WIDTH-1:0]   r_reg [4];
  logic [1:0]                      r_aw_idx;
  logic                            r_aw_held;
  logic [C_S_AXI_DATA_WIDTH-1:0]   r_wdata;
  logic [3:0]                      r_wstrb;
  logic                            r_w_held;
  logic                            r_awready;
  logic                            r_wready;
  logic                            r_bvalid;
  logic [3:0]                      r_wr_pulse;
  logic                            r_arready;
  logic                            r_rvalid;
  logic [C_S_AXI_DATA_WIDTH-1:0]   r_rdata;

  logic                            w_aw_hs;
  logic                            w_w_hs;
  logic                            w_commit;
  logic [1:0]                      w_idx;
  logic [C_S_AXI_DATA_WIDTH-1:0]   w_data;
  logic [3:0]                      w_strb;
  logic                            w_reg_we;
  logic                            w_ar_hs;
  logic [1:0]                      w_rd_idx;
  logic [C_S_AXI_DATA_WIDTH-1:0]   w_rd_val;
  logic                            w_unused;

  assign w_aw_hs  = s00_axi_awvalid & r_awready;
  assign w_w_hs   = s00_axi_wvalid & r_wready;
  // A live handshake counts as held, so AW and W in the same cycle commit on that edge.
  assign w_commit = (r_aw_held | w_aw_hs) & (r_w_held | w_w_hs);
  assign w_idx    = r_aw_held ? r_aw_idx : s00_axi_awaddr[3:2];
  assign w_data   = r_w_held ? r_wdata : s00_axi_wdata;
  assign w_strb   = r_w_held ? r_wstrb : s00_axi_wstrb;
  assign w_ar_hs  = s00_axi_arvalid & r_arready;
  assign w_rd_idx = s00_axi_araddr[3:2];

`ifdef SPI_ACL2_HW_STATUS_EN
  assign w_reg_we = (w_idx != 2'd3);
  assign w_rd_val = (w_rd_idx == 2'd3) ? status_in : r_reg[w_rd_idx];
  assign reg3_out = status_in;
  assign w_unused = &{1'b0, s00_axi_awprot, s00_axi_arprot, s00_axi_awaddr[1:0],
                      s00_axi_araddr[1:0], r_reg[3]};
`else
  assign w_reg_we = 1'b1;
  assign w_rd_val = r_reg[w_rd_idx];
  assign reg3_out = r_reg[3];
  assign w_unused = &{1'b0, s00_axi_awprot, s00_axi_arprot, s00_axi_awaddr[1:0],
                      s00_axi_araddr[1:0], status_in};
`endif

  always_ff @(posedge s00_axi_aclk) begin
    if (!s00_axi_aresetn) begin
      r_wstate   <= W_IDLE;
      r_aw_held  <= 1'b0;
      r_w_held   <= 1'b0;
      r_aw_idx   <= '0;
      r_wdata    <= '0;
      r_wstrb    <= '0;
      r_awready  <= 1'b0;
      r_wready   <= 1'b0;
      r_bvalid   <= 1'b0;
      r_wr_pulse <= '0;
      for (int i = 0; i < 4; i++) r_reg[i] <= '0;
    end else begin
      r_wr_pulse <= '0;
      case (r_wstate)
        W_RESP: begin
          if (s00_axi_bready) begin
            r_bvalid  <= 1'b0;
            r_awready <= 1'b1;
            r_wready  <= 1'b1;
            r_wstate  <= W_IDLE;
          end
        end
        default: begin
          if (w_commit) begin
            for (int k = 0; k < 4; k++) begin
              if (w_reg_we && w_strb[k]) r_reg[w_idx][8*k +: 8] <= w_data[8*k +: 8];
            end
            r_wr_pulse[w_idx] <= 1'b1;
            r_bvalid  <= 1'b1;
            r_aw_held <= 1'b0;
            r_w_held  <= 1'b0;
            r_awready <= 1'b0;
            r_wready  <= 1'b0;
            r_wstate  <= W_RESP;
          end else begin
            r_awready <= ~(r_aw_held | w_aw_hs);
            r_wready  <= ~(r_w_held | w_w_hs);
            if (w_aw_hs) begin
              r_aw_idx  <= s00_axi_awaddr[3:2];
              r_aw_held <= 1'b1;
            end
            if (w_w_hs) begin
              r_wdata  <= s00_axi_wdata;
              r_wstrb  <= s00_axi_wstrb;
              r_w_held <= 1'b1;
            end
            if (w_aw_hs || w_w_hs) r_wstate <= W_HALF;
          end
        end
      endcase
    end
  end

  always_ff @(posedge s00_axi_aclk) begin
    if (!s00_axi_aresetn) begin
      r_rstate  <= R_IDLE;
      r_arready <= 1'b0;
      r_rvalid  <= 1'b0;
      r_rdata   <= '0;
    end else begin
      case (r_rstate)
        R_IDLE: begin
          if (w_ar_hs) begin
            r_rdata   <= w_rd_val;
            r_rvalid  <= 1'b1;
            r_arready <= 1'b0;
            r_rstate  <= R_RESP;
          end else begin
            r_arready <= 1'b1;
          end
        end
        default: begin
          if (s00_axi_rready) begin
            r_rvalid  <= 1'b0;
            r_arready <= 1'b1;
            r_rstate  <= R_IDLE;
          end
        end
      endcase
    end
  end

  assign s00_axi_awready = r_awready;
  assign s00_axi_wready  = r_wready;
  assign s00_axi_bvalid  = r_bvalid;
  assign s00_axi_bresp   = 2'b00;
  assign s00_axi_arready = r_arready;
  assign s00_axi_rvalid  = r_rvalid;
  assign s00_axi_rdata   = r_rdata;
  assign s00_axi_rresp   = 2'b00;
  assign wr_pulse        = r_wr_pulse;
  assign reg0_out        = r_reg[0];
  assign reg1_out        = r_reg[1];
  assign reg2_out        = r_reg[2];

endmodule

// File: tb/tb_spi_acl2_axil_slave.sv
// tb/tb_spi_acl2_axil_slave.sv - directed vector bench for spi_acl2_axil_slave
module tb_spi_acl2_axil_slave;

  localparam logic [31:0] STATUS = 32'h12345678;

  logic        clk = 1'b0;
  logic        resetn;
  logic [3:0]  awaddr, araddr;
  logic [2:0]  awprot, arprot;
  logic        awvalid, awready, wvalid, wready, bvalid, bready;
  logic        arvalid, arready, rvalid, rready;
  logic [31:0] wdata, rdata, status_in;
  logic [3:0]  wstrb, wr_pulse;
  logic [1:0]  bresp, rresp;
  logic [31:0] reg0_out, reg1_out, reg2_out, reg3_out;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  spi_acl2_axil_slave dut (
    .s00_axi_aclk(clk), .s00_axi_aresetn(resetn),
    .s00_axi_awaddr(awaddr), .s00_axi_awprot(awprot), .s00_axi_awvalid(awvalid),
    .s00_axi_awready(awready), .s00_axi_wdata(wdata), .s00_axi_wstrb(wstrb),
    .s00_axi_wvalid(wvalid), .s00_axi_wready(wready), .s00_axi_bresp(bresp),
    .s00_axi_bvalid(bvalid), .s00_axi_bready(bready), .s00_axi_araddr(araddr),
    .s00_axi_arprot(arprot), .s00_axi_arvalid(arvalid), .s00_axi_arready(arready),
    .s00_axi_rdata(rdata), .s00_axi_rresp(rresp), .s00_axi_rvalid(rvalid),
    .s00_axi_rready(rready), .reg0_out(reg0_out), .reg1_out(reg1_out),
    .reg2_out(reg2_out), .reg3_out(reg3_out), .wr_pulse(wr_pulse), .status_in(status_in)
  );

  typedef struct {
    logic [3:0]  addr;
    logic [31:0] data;
    logic [3:0]  strb;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs [4];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] reg_out(input logic [1:0] i);
    case (i)
      2'd0: return reg0_out;
      2'd1: return reg1_out;
      2'd2: return reg2_out;
      default: return reg3_out;
    endcase
  endfunction

  task automatic axi_write(input logic [3:0] addr, input logic [31:0] data, input logic [3:0] strb);
    int t;
    logic [1:0] idx;
    idx = addr[3:2];
    awaddr = addr; wdata = data; wstrb = strb;
    awvalid = 1'b1; wvalid = 1'b1; bready = 1'b1;
    t = 0;
    while (!(awready && wready) && t < 20) begin
      @(negedge clk);
      t++;
    end
    chk("wr_ready_timeout", {31'd0, t < 20}, 32'd1);
    @(negedge clk);
    awvalid = 1'b0; wvalid = 1'b0;
    chk("wr_bvalid", {31'd0, bvalid}, 32'd1);
    chk("wr_bresp", {30'd0, bresp}, 32'd0);
    chk("wr_pulse", {28'd0, wr_pulse}, {28'd0, 4'b0001 << idx});
    @(negedge clk);
    chk("wr_pulse_clear", {28'd0, wr_pulse}, 32'd0);
    chk("wr_bvalid_clear", {31'd0, bvalid}, 32'd0);
  endtask

  task automatic axi_read(input logic [3:0] addr, output logic [31:0] data);
    int t;
    araddr = addr; arvalid = 1'b1; rready = 1'b1;
    t = 0;
    while (!arready && t < 20) begin
      @(negedge clk);
      t++;
    end
    chk("rd_ready_timeout", {31'd0, t < 20}, 32'd1);
    @(negedge clk);
    arvalid = 1'b0;
    chk("rd_rvalid", {31'd0, rvalid}, 32'd1);
    chk("rd_rresp", {30'd0, rresp}, 32'd0);
    data = rdata;
    @(negedge clk);
    chk("rd_rvalid_clear", {31'd0, rvalid}, 32'd0);
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_awready"}, {31'd0, awready}, 32'd0);
    chk({tag, "_wready"},  {31'd0, wready},  32'd0);
    chk({tag, "_bvalid"},  {31'd0, bvalid},  32'd0);
    chk({tag, "_arready"}, {31'd0, arready}, 32'd0);
    chk({tag, "_rvalid"},  {31'd0, rvalid},  32'd0);
    chk({tag, "_rdata"},   rdata, 32'd0);
    chk({tag, "_wr_pulse"}, {28'd0, wr_pulse}, 32'd0);
    chk({tag, "_reg0"}, reg0_out, 32'd0);
    chk({tag, "_reg1"}, reg1_out, 32'd0);
    chk({tag, "_reg2"}, reg2_out, 32'd0);
`ifdef SPI_ACL2_HW_STATUS_EN
    chk({tag, "_reg3"}, reg3_out, STATUS);
`else
    chk({tag, "_reg3"}, reg3_out, 32'd0);
`endif
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    logic [31:0] rd;

    vecs[0] = '{4'h0, 32'h1, 4'hF, 32'h1};
    vecs[1] = '{4'h4, 32'h2, 4'hF, 32'h2};
    vecs[2] = '{4'h8, 32'h3, 4'hF, 32'h3};
`ifdef SPI_ACL2_HW_STATUS_EN
    vecs[3] = '{4'hC, 32'h4, 4'hF, STATUS};
`else
    vecs[3] = '{4'hC, 32'h4, 4'hF, 32'h4};
`endif

    resetn = 1'b0; status_in = STATUS;
    awaddr = '0; awprot = '0; awvalid = 1'b0; wdata = '0; wstrb = '0; wvalid = 1'b0;
    bready = 1'b0; araddr = '0; arprot = '0; arvalid = 1'b0; rready = 1'b0;
    repeat (3) @(negedge clk);
    chk_reset_state("init");
    resetn = 1'b1;
    @(negedge clk);
    chk("post_reset_awready", {31'd0, awready}, 32'd1);
    chk("post_reset_arready", {31'd0, arready}, 32'd1);

    for (int i = 0; i < 4; i++) axi_write(vecs[i].addr, vecs[i].data, vecs[i].strb);
    for (int i = 0; i < 4; i++) begin
      axi_read(vecs[i].addr, rd);
      chk($sformatf("vec%0d_rdata", i), rd, vecs[i].exp);
      chk($sformatf("vec%0d_reg_out", i), reg_out(vecs[i].addr[3:2]), vecs[i].exp);
    end

    axi_write(4'h4, 32'hAABBCCDD, 4'hF);
    axi_write(4'h4, 32'h11223344, 4'b0101);
    axi_read(4'h4, rd);
    chk("strb_merge", rd, 32'hAA22CC44);

    axi_write(4'h8, 32'hFFFFFFFF, 4'h0);
    chk("strb_zero_reg2", reg2_out, 32'h3);

    // W leads AW by three cycles
    wdata = 32'hDEADBEEF; wstrb = 4'hF; wvalid = 1'b1; bready = 1'b1;
    chk("wfirst_wready", {31'd0, wready}, 32'd1);
    @(negedge clk);
    wvalid = 1'b0;
    chk("wfirst_wready_drop", {31'd0, wready}, 32'd0);
    chk("wfirst_no_bvalid", {31'd0, bvalid}, 32'd0);
    repeat (2) @(negedge clk);
    chk("wfirst_still_no_bvalid", {31'd0, bvalid}, 32'd0);
    chk("wfirst_awready", {31'd0, awready}, 32'd1);
    awaddr = 4'h8; awvalid = 1'b1;
    @(negedge clk);
    awvalid = 1'b0;
    chk("wfirst_bvalid", {31'd0, bvalid}, 32'd1);
    chk("wfirst_pulse", {28'd0, wr_pulse}, 32'h4);
    chk("wfirst_reg2", reg2_out, 32'hDEADBEEF);
    @(negedge clk);
    chk("wfirst_bvalid_clear", {31'd0, bvalid}, 32'd0);

    // B back-pressure with a second write waiting
    bready = 1'b0; awaddr = 4'h0; wdata = 32'h77; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
    @(negedge clk);
    awaddr = 4'h4; wdata = 32'h99;
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("bp%0d_bvalid", i), {31'd0, bvalid}, 32'd1);
      chk($sformatf("bp%0d_awready", i), {31'd0, awready}, 32'd0);
      chk($sformatf("bp%0d_wready", i), {31'd0, wready}, 32'd0);
      @(negedge clk);
    end
    chk("bp_reg1_untouched", reg1_out, 32'hAA22CC44);
    bready = 1'b1;
    @(negedge clk);
    chk("bp_bvalid_drop", {31'd0, bvalid}, 32'd0);
    chk("bp_awready_back", {31'd0, awready}, 32'd1);
    chk("bp_wready_back", {31'd0, wready}, 32'd1);
    @(negedge clk);
    awvalid = 1'b0; wvalid = 1'b0;
    chk("bp_second_bvalid", {31'd0, bvalid}, 32'd1);
    chk("bp_reg1", reg1_out, 32'h99);
    chk("bp_reg0", reg0_out, 32'h77);
    @(negedge clk);

    // R stalled while the same register is rewritten
    araddr = 4'h0; arvalid = 1'b1; rready = 1'b0;
    @(negedge clk);
    arvalid = 1'b0;
    awaddr = 4'h0; wdata = 32'h55; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1; bready = 1'b1;
    @(negedge clk);
    awvalid = 1'b0; wvalid = 1'b0;
    chk("stall_reg0_new", reg0_out, 32'h55);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("stall%0d_rvalid", i), {31'd0, rvalid}, 32'd1);
      chk($sformatf("stall%0d_rdata", i), rdata, 32'h77);
      chk($sformatf("stall%0d_arready", i), {31'd0, arready}, 32'd0);
      @(negedge clk);
    end
    rready = 1'b1;
    @(negedge clk);
    chk("stall_rvalid_drop", {31'd0, rvalid}, 32'd0);
    axi_read(4'h0, rd);
    chk("stall_reread", rd, 32'h55);

    // Read handshake on the same edge as a commit to that register
    araddr = 4'h4; arvalid = 1'b1; rready = 1'b1;
    awaddr = 4'h4; wdata = 32'hABCD0123; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
    @(negedge clk);
    arvalid = 1'b0; awvalid = 1'b0; wvalid = 1'b0;
    chk("coinc_rdata_old", rdata, 32'h99);
    chk("coinc_rvalid", {31'd0, rvalid}, 32'd1);
    chk("coinc_reg1_new", reg1_out, 32'hABCD0123);
    chk("coinc_bvalid", {31'd0, bvalid}, 32'd1);
    @(negedge clk);
    chk("coinc_rvalid_drop", {31'd0, rvalid}, 32'd0);

    // Reset with an address held and no data yet
    awaddr = 4'h8; awvalid = 1'b1;
    @(negedge clk);
    awvalid = 1'b0;
    chk("midrst_aw_held", {31'd0, awready}, 32'd0);
    resetn = 1'b0;
    @(negedge clk);
    chk_reset_state("midrst");
    resetn = 1'b1;
    @(negedge clk);
    wdata = 32'hCAFEF00D; wstrb = 4'hF; wvalid = 1'b1;
    @(negedge clk);
    wvalid = 1'b0;
    chk("midrst_no_commit_bvalid", {31'd0, bvalid}, 32'd0);
    chk("midrst_no_commit_pulse", {28'd0, wr_pulse}, 32'd0);
    repeat (3) @(negedge clk);
    chk("midrst_still_idle", {31'd0, bvalid}, 32'd0);
    chk("midrst_reg2", reg2_out, 32'd0);
    awaddr = 4'h8; awvalid = 1'b1;
    @(negedge clk);
    awvalid = 1'b0;
    chk("midrst_late_aw_bvalid", {31'd0, bvalid}, 32'd1);
    chk("midrst_late_aw_reg2", reg2_out, 32'hCAFEF00D);
    @(negedge clk);
    axi_read(4'hC, rd);
`ifdef SPI_ACL2_HW_STATUS_EN
    chk("midrst_read3", rd, STATUS);
`else
    chk("midrst_read3", rd, 32'd0);
`endif
    axi_read(4'h0, rd);
    chk("midrst_read0", rd, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
